// File: rtl/mcc_pkg.sv
// mcc_pkg: shared opcode/funct constants, ALU command bit indices and FSM encoding
package mcc_pkg;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;
    typedef enum logic [1:0] {BR_NONE, BR_EQ, BR_NE} br_t;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0A;
    localparam logic [5:0] OPC_SLTIU = 6'h0B;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADD  = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    function automatic logic [11:0] alu_bit(input int idx);
        return 12'b1 << idx;
    endfunction

endpackage

// File: rtl/mcc_alu_dec.sv
// mcc_alu_dec: combinational MIPS decode into ALU command, operands and writeback control
module mcc_alu_dec
    import mcc_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [11:0] alu_op,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [4:0]  dest,
    output logic        we,
    output br_t         br,
    output logic        illegal
);

    logic [5:0]  opc;
    logic [5:0]  fn;
    logic [31:0] sext;
    logic [31:0] zext;
    logic        unused_rs_field;

    assign opc  = instr[31:26];
    assign fn   = instr[5:0];
    assign sext = {{16{instr[15]}}, instr[15:0]};
    assign zext = {16'b0, instr[15:0]};
    // register operands arrive as values, so the rs field itself is not needed
    assign unused_rs_field = ^instr[25:21];

    // map opcode/funct onto a one-hot ALU command; anything unknown is illegal with no write
    always_comb begin
        alu_op  = '0;
        a       = rs;
        b       = rt;
        dest    = instr[15:11];
        we      = 1'b1;
        br      = BR_NONE;
        illegal = 1'b0;
        if (opc == OPC_RTYPE) begin
            case (fn)
                F_ADD:  alu_op = alu_bit(ALU_ADD);
                F_SUB:  alu_op = alu_bit(ALU_SUB);
                F_AND:  alu_op = alu_bit(ALU_AND);
                F_OR:   alu_op = alu_bit(ALU_OR);
                F_XOR:  alu_op = alu_bit(ALU_XOR);
                F_NOR:  alu_op = alu_bit(ALU_NOR);
                F_SLT:  alu_op = alu_bit(ALU_SLT);
                F_SLTU: alu_op = alu_bit(ALU_SLTU);
                F_SLL:  begin alu_op = alu_bit(ALU_SLL); a = {27'b0, instr[10:6]}; end
                F_SRL:  begin alu_op = alu_bit(ALU_SRL); a = {27'b0, instr[10:6]}; end
                F_SRA:  begin alu_op = alu_bit(ALU_SRA); a = {27'b0, instr[10:6]}; end
                F_SLLV: alu_op = alu_bit(ALU_SLL);
                F_SRLV: alu_op = alu_bit(ALU_SRL);
                F_SRAV: alu_op = alu_bit(ALU_SRA);
                default: begin we = 1'b0; illegal = 1'b1; end
            endcase
        end else begin
            dest = instr[20:16];
            b    = sext;
            case (opc)
                OPC_ADDIU: alu_op = alu_bit(ALU_ADD);
                OPC_SLTI:  alu_op = alu_bit(ALU_SLT);
                OPC_SLTIU: alu_op = alu_bit(ALU_SLTU);
                OPC_ANDI:  begin alu_op = alu_bit(ALU_AND); b = zext; end
                OPC_ORI:   begin alu_op = alu_bit(ALU_OR);  b = zext; end
                OPC_XORI:  begin alu_op = alu_bit(ALU_XOR); b = zext; end
                OPC_LUI:   begin alu_op = alu_bit(ALU_LUI); b = zext; end
                OPC_BEQ:   begin alu_op = alu_bit(ALU_SUB); b = rt; we = 1'b0; br = BR_EQ; end
                OPC_BNE:   begin alu_op = alu_bit(ALU_SUB); b = rt; we = 1'b0; br = BR_NE; end
                default:   begin we = 1'b0; illegal = 1'b1; end
            endcase
        end
    end

endmodule

// File: rtl/mcc_alu_seq.sv
// mcc_alu_seq: four-state sequencer driving an external ALU and presenting a writeback bundle
module mcc_alu_seq
    import mcc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    output logic [11:0] alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_we,
    output logic [4:0]  out_waddr,
    output logic [31:0] out_wdata,
    output logic        out_br_taken,
    output logic        out_illegal
);

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d, rs_q, rs_d, rt_q, rt_d;
    br_t         br_q, br_d;
    logic [11:0] alu_op_q, alu_op_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic        out_we_q, out_we_d, out_br_taken_q, out_br_taken_d, out_illegal_q, out_illegal_d;
    logic [4:0]  out_waddr_q, out_waddr_d;
    logic [31:0] out_wdata_q, out_wdata_d;

    logic [11:0] dec_op;
    logic [31:0] dec_a, dec_b;
    logic [4:0]  dec_dest;
    logic        dec_we, dec_illegal;
    br_t         dec_br;

    mcc_alu_dec u_dec (
        .instr   (instr_q),
        .rs      (rs_q),
        .rt      (rt_q),
        .alu_op  (dec_op),
        .a       (dec_a),
        .b       (dec_b),
        .dest    (dec_dest),
        .we      (dec_we),
        .br      (dec_br),
        .illegal (dec_illegal)
    );

    assign in_ready     = (state_q == S_IDLE);
    assign out_valid    = (state_q == S_WB);
    assign alu_op       = alu_op_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign out_we       = out_we_q;
    assign out_waddr    = out_waddr_q;
    assign out_wdata    = out_wdata_q;
    assign out_br_taken = out_br_taken_q;
    assign out_illegal  = out_illegal_q;

    // next-state: capture bundle, latch decode, issue command for one cycle, then sample the ALU
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        rs_d           = rs_q;
        rt_d           = rt_q;
        br_d           = br_q;
        alu_op_d       = alu_op_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        out_we_d       = out_we_q;
        out_waddr_d    = out_waddr_q;
        out_wdata_d    = out_wdata_q;
        out_br_taken_d = out_br_taken_q;
        out_illegal_d  = out_illegal_q;
        case (state_q)
            S_IDLE: if (in_valid) begin
                state_d = S_DECODE;
                instr_d = in_instr;
                rs_d    = in_rs;
                rt_d    = in_rt;
            end
            S_DECODE: begin
                state_d       = S_EXEC;
                alu_op_d      = dec_op;
                alu_a_d       = dec_a;
                alu_b_d       = dec_b;
                out_waddr_d   = dec_dest;
                out_we_d      = dec_we && (dec_dest != 5'd0);
                br_d          = dec_br;
                out_illegal_d = dec_illegal;
            end
            S_EXEC: begin
                state_d        = S_WB;
                alu_op_d       = '0;
                out_wdata_d    = out_illegal_q ? '0 : alu_result;
                out_br_taken_d = (br_q == BR_EQ && alu_zero) || (br_q == BR_NE && !alu_zero);
            end
            S_WB: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and registered outputs; reset drops any in-flight instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            instr_q        <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            br_q           <= BR_NONE;
            alu_op_q       <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            out_we_q       <= 1'b0;
            out_waddr_q    <= '0;
            out_wdata_q    <= '0;
            out_br_taken_q <= 1'b0;
            out_illegal_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            br_q           <= br_d;
            alu_op_q       <= alu_op_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            out_we_q       <= out_we_d;
            out_waddr_q    <= out_waddr_d;
            out_wdata_q    <= out_wdata_d;
            out_br_taken_q <= out_br_taken_d;
            out_illegal_q  <= out_illegal_d;
        end
    end

endmodule

// File: tb/tb_mcc_alu_seq.sv
// tb_mcc_alu_seq: vector table plus scoreboard for the sequenced ALU front end
module tb_mcc_alu_seq;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [11:0] op;
        logic        chk_a;
        logic [31:0] a;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        br;
        logic        ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_instr = '0, in_rs = '0, in_rt = '0;
    logic        in_ready, out_valid, out_we, out_br_taken, out_illegal, alu_zero;
    logic [11:0] alu_op;
    logic [31:0] alu_a, alu_b, alu_result, out_wdata;
    logic [4:0]  out_waddr;

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[$];
    vec_t sb[$];
    vec_t e;

    mcc_alu_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_instr     (in_instr),
        .in_rs        (in_rs),
        .in_rt        (in_rt),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_we       (out_we),
        .out_waddr    (out_waddr),
        .out_wdata    (out_wdata),
        .out_br_taken (out_br_taken),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    // reference ALU; an idle command yields a poison value so forced-zero results are visible
    always_comb begin
        case (alu_op)
            12'h001: alu_result = alu_a + alu_b;
            12'h002: alu_result = alu_a - alu_b;
            12'h004: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
            12'h008: alu_result = {31'b0, alu_a < alu_b};
            12'h010: alu_result = alu_a & alu_b;
            12'h020: alu_result = ~(alu_a | alu_b);
            12'h040: alu_result = alu_a | alu_b;
            12'h080: alu_result = alu_a ^ alu_b;
            12'h100: alu_result = alu_b << alu_a[4:0];
            12'h200: alu_result = alu_b >> alu_a[4:0];
            12'h400: alu_result = $signed(alu_b) >>> alu_a[4:0];
            12'h800: alu_result = {alu_b[15:0], 16'b0};
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // pop the scoreboard whenever a writeback bundle is consumed
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("out_we", out_we, e.we);
                if (e.we) chk("out_waddr", out_waddr, e.waddr);
                chk("out_wdata", out_wdata, e.wdata);
                chk("out_br_taken", out_br_taken, e.br);
                chk("out_illegal", out_illegal, e.ill);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", in_ready, 1);
    endtask

    task automatic send(input vec_t v, input bit push);
        wait_idle();
        in_valid = 1'b1;
        in_instr = v.instr;
        in_rs    = v.rs;
        in_rt    = v.rt;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) sb.push_back(v);
        chk("decode_in_ready", in_ready, 0);
    endtask

    task automatic run(input vec_t v);
        send(v, 1'b1);
        @(posedge clk); #1;
        chk("exec_alu_op", alu_op, v.op);
        if (v.chk_a) chk("exec_alu_a", alu_a, v.a);
        @(posedge clk); #1;
        chk("wb_out_valid", out_valid, 1);
        chk("wb_alu_op_idle", alu_op, 0);
        wait_idle();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] snap;
        int seen;
        vecs.push_back('{32'h00221821, 32'd5, 32'd7, 12'h001, 1'b1, 32'd5, 1'b1, 5'd3, 32'd12, 1'b0, 1'b0});
        vecs.push_back('{32'h00221823, 32'd5, 32'd7, 12'h002, 1'b1, 32'd5, 1'b1, 5'd3, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h0022182A, 32'hFFFFFFFF, 32'd1, 12'h004, 1'b0, 32'd0, 1'b1, 5'd3, 32'd1, 1'b0, 1'b0});
        vecs.push_back('{32'h0022182B, 32'hFFFFFFFF, 32'd1, 12'h008, 1'b0, 32'd0, 1'b1, 5'd3, 32'd0, 1'b0, 1'b0});
        vecs.push_back('{32'h00221827, 32'hF0F0F0F0, 32'h0F0F0000, 12'h020, 1'b0, 32'd0, 1'b1, 5'd3, 32'h00000F0F, 1'b0, 1'b0});
        vecs.push_back('{32'h00052103, 32'd0, 32'h80000000, 12'h400, 1'b1, 32'd4, 1'b1, 5'd4, 32'hF8000000, 1'b0, 1'b0});
        vecs.push_back('{32'h00052102, 32'd0, 32'h80000000, 12'h200, 1'b1, 32'd4, 1'b1, 5'd4, 32'h08000000, 1'b0, 1'b0});
        vecs.push_back('{32'h00221804, 32'd4, 32'd1, 12'h100, 1'b1, 32'd4, 1'b1, 5'd3, 32'h10, 1'b0, 1'b0});
        vecs.push_back('{32'h10220003, 32'd9, 32'd9, 12'h002, 1'b1, 32'd9, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0});
        vecs.push_back('{32'h14220003, 32'd9, 32'd9, 12'h002, 1'b1, 32'd9, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0});
        vecs.push_back('{32'h14220003, 32'd9, 32'd3, 12'h002, 1'b1, 32'd9, 1'b0, 5'd0, 32'd6, 1'b1, 1'b0});
        vecs.push_back('{32'h3C071234, 32'd0, 32'd0, 12'h800, 1'b0, 32'd0, 1'b1, 5'd7, 32'h12340000, 1'b0, 1'b0});
        vecs.push_back('{32'h24000001, 32'd0, 32'd0, 12'h001, 1'b0, 32'd0, 1'b0, 5'd0, 32'd1, 1'b0, 1'b0});
        vecs.push_back('{32'h3022FFFF, 32'h12345678, 32'd0, 12'h010, 1'b0, 32'd0, 1'b1, 5'd2, 32'h5678, 1'b0, 1'b0});
        vecs.push_back('{32'h2822FFFF, 32'hFFFFFFFE, 32'd0, 12'h004, 1'b0, 32'd0, 1'b1, 5'd2, 32'd1, 1'b0, 1'b0});
        vecs.push_back('{32'h34228000, 32'h00010000, 32'd0, 12'h040, 1'b0, 32'd0, 1'b1, 5'd2, 32'h00018000, 1'b0, 1'b0});
        vecs.push_back('{32'h38221111, 32'h1111, 32'd0, 12'h080, 1'b0, 32'd0, 1'b1, 5'd2, 32'd0, 1'b0, 1'b0});
        vecs.push_back('{32'h00221820, 32'd5, 32'd7, 12'h000, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1});
        vecs.push_back('{32'h00220021, 32'd5, 32'd7, 12'h001, 1'b0, 32'd0, 1'b0, 5'd0, 32'd12, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_bundle", {out_we, out_waddr, out_wdata, out_br_taken, out_illegal}, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) run(vecs[i]);

        // illegal opcode held in WB by backpressure, with a competing bundle offered meanwhile
        out_ready = 1'b0;
        send('{32'hFC000000, 32'd1, 32'd2, 12'h000, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1}, 1'b1);
        @(posedge clk); #1;
        chk("ill_exec_alu_op", alu_op, 0);
        @(posedge clk); #1;
        chk("ill_wb_illegal", out_illegal, 1);
        snap = {out_we, out_waddr, out_wdata, out_br_taken, out_illegal};
        in_valid = 1'b1;
        in_instr = 32'h00221821;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_alu_op", alu_op, 0);
            chk("stall_bundle", {out_we, out_waddr, out_wdata, out_br_taken, out_illegal}, snap);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // reset while executing: nothing must come out for the dropped instruction
        send(vecs[0], 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_alu_op", alu_op, 12'h001);
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_alu_op", alu_op, 0);
        chk("midrst_alu_ab", {alu_a, alu_b}, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_bundle", {out_we, out_waddr, out_wdata, out_br_taken, out_illegal}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("post_rst_no_valid", seen, 0);
        run(vecs[5]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
